fifo_burst_reader: RTL and testbench

Downstream read-side stage for the first-word-fall-through synchronous FIFO. It watches the FIFO occupancy, pops fixed-length bursts through the FWFT read port, and presents them on a valid/ready stream with a `last` marker per burst. Partial bursts are released on an idle timeout or an explicit flush. A 2-entry skid buffer decouples FIFO pops from consumer backpressure.

---
 rtl/fifo_burst_reader_if.sv | 23 ++
 rtl/fifo_burst_reader.sv | 116 +++++++++++
 tb/tb_fifo_burst_reader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// Valid/ready stream carrying burst words and a per-burst last marker.
interface fifo_burst_reader_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  m_valid_o;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_last_o;
    logic                  m_ready_i;

    modport master (
        output m_valid_o,
        output m_data_o,
        output m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  m_valid_o,
        input  m_data_o,
        input  m_last_o,
        output m_ready_i
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops fixed-length bursts from an FWFT FIFO into a 2-entry skid buffer and
// streams them out with a last marker; partial bursts leave on timeout or flush.
module fifo_burst_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_ren_o,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    input  logic                  fifo_empty_i,
    input  logic [CNT_WIDTH-1:0]  fifo_count_i,
    input  logic                  flush_i,
    fifo_burst_reader_if.master   m_if,
    output logic                  busy_o
);

    localparam int unsigned TO_WIDTH = $clog2(TIMEOUT) + 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  remain_q;
    logic [TO_WIDTH-1:0]   to_cnt_q;
    logic [DATA_WIDTH-1:0] data0_q;
    logic [DATA_WIDTH-1:0] data1_q;
    logic                  last0_q;
    logic                  last1_q;
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;

    logic                  full_burst;
    logic                  start;
    logic [CNT_WIDTH-1:0]  start_len;
    logic                  push;
    logic                  pop;

    always_comb begin
        full_burst = fifo_count_i >= CNT_WIDTH'(BURST_LEN);
        start      = full_burst ||
                     ((fifo_count_i != '0) &&
                      (flush_i || (to_cnt_q == TO_WIDTH'(TIMEOUT - 1))));
        start_len  = full_burst ? CNT_WIDTH'(BURST_LEN) : fifo_count_i;
        // Pop only when the registered occupancy guarantees a free slot.
        push       = (state_q == BURST) && (remain_q != '0) &&
                     !fifo_empty_i && (occ_q < 2'd2);
        pop        = (occ_q != 2'd0) && m_if.m_ready_i;
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    end

    assign fifo_ren_o     = push;
    assign m_if.m_valid_o = (occ_q != 2'd0);
    assign m_if.m_data_o  = data0_q;
    assign m_if.m_last_o  = last0_q;
    assign busy_o         = (state_q != IDLE) || (occ_q != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            remain_q <= '0;
            to_cnt_q <= '0;
            data0_q  <= '0;
            data1_q  <= '0;
            last0_q  <= 1'b0;
            last1_q  <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            occ_q <= occ_d;

            if (pop) begin
                data0_q <= data1_q;
                last0_q <= last1_q;
            end
            // A push lands at the head when the buffer is, or becomes, empty.
            if (push) begin
                if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
                    data0_q <= fifo_rdata_i;
                    last0_q <= (remain_q == CNT_WIDTH'(1));
                end else begin
                    data1_q <= fifo_rdata_i;
                    last1_q <= (remain_q == CNT_WIDTH'(1));
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= BURST;
                        remain_q <= start_len;
                        to_cnt_q <= '0;
                    end else if (fifo_count_i == '0) begin
                        to_cnt_q <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_WIDTH'(1);
                    end
                end
                BURST: begin
                    if (push) begin
                        remain_q <= remain_q - CNT_WIDTH'(1);
                        if (remain_q == CNT_WIDTH'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader driven by a behavioural FWFT FIFO.
module tb_fifo_burst_reader;

    localparam int unsigned DW  = 8;
    localparam int unsigned CW  = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_ren;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          flush = 1'b0;
    logic          busy;

    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          stall   = 1'b0;
    logic [CW-1:0] cnt_q   = '0;
    logic [DW-1:0] head_q  = '0;
    logic          empty_q = 1'b1;
    logic [DW-1:0] fq[$];
    logic [DW:0]   recv[$];
    int            pop_cnt = 0;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_burst_reader_if #(.DATA_WIDTH(DW)) s_if ();

    fifo_burst_reader #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(32),
        .CNT_WIDTH (CW),
        .BURST_LEN (4),
        .TIMEOUT   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_ren_o  (fifo_ren),
        .fifo_rdata_i(fifo_rdata),
        .fifo_empty_i(fifo_empty),
        .fifo_count_i(fifo_count),
        .flush_i     (flush),
        .m_if        (s_if),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    assign fifo_count = cnt_q;
    assign fifo_rdata = head_q;
    assign fifo_empty = empty_q | stall;

    // FWFT FIFO model with a registered count.
    always @(posedge clk) begin
        if (fifo_ren && fq.size() != 0) begin
            void'(fq.pop_front());
            pop_cnt++;
        end
        if (wr_en) fq.push_back(wr_data);
        cnt_q   <= CW'(fq.size());
        head_q  <= (fq.size() != 0) ? fq[0] : '0;
        empty_q <= (fq.size() == 0);
    end

    always @(posedge clk) begin
        if (!rst && s_if.m_valid_o && s_if.m_ready_i)
            recv.push_back({s_if.m_last_o, s_if.m_data_o});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = DW'(base + DW'(i));
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_beats(input string tag, input int base, input int n,
                               input logic [DW-1:0] first, input logic [7:0] last_mask);
        check({tag, "_count"}, 32'(recv.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < recv.size()) begin
                check($sformatf("%s_data%0d", tag, i), 32'(recv[base+i][DW-1:0]), 32'(DW'(first + DW'(i))));
                check($sformatf("%s_last%0d", tag, i), 32'(recv[base+i][DW]), 32'(last_mask[i]));
            end
        end
    endtask

    initial begin
        int base;
        int pops0;
        s_if.m_ready_i = 1'b1;

        // Reset state
        cycles(2);
        check("rst_ren",   32'(fifo_ren),         0);
        check("rst_valid", 32'(s_if.m_valid_o),   0);
        check("rst_data",  32'(s_if.m_data_o),    0);
        check("rst_last",  32'(s_if.m_last_o),    0);
        check("rst_busy",  32'(busy),             0);
        rst = 1'b0;
        cycles(2);

        // Full burst: valid two cycles after count reaches 4
        base = recv.size();
        wr(4, 8'h10);
        check("full_ren_t",   32'(fifo_ren),       0);
        check("full_valid_t", 32'(s_if.m_valid_o), 0);
        @(negedge clk);
        check("full_ren_t1",   32'(fifo_ren),       1);
        check("full_valid_t1", 32'(s_if.m_valid_o), 0);
        check("full_busy_t1",  32'(busy),           1);
        @(negedge clk);
        check("full_valid_t2", 32'(s_if.m_valid_o), 1);
        check("full_data_t2",  32'(s_if.m_data_o),  32'h10);
        cycles(8);
        check_beats("full", base, 4, 8'h10, 8'b0000_1000);
        check("full_busy_end", 32'(busy), 0);

        // Backpressure: two pops then hold
        base  = recv.size();
        pops0 = pop_cnt;
        s_if.m_ready_i = 1'b0;
        wr(8, 8'h20);
        cycles(10);
        check("bp_pops",  32'(pop_cnt - pops0),  2);
        check("bp_ren",   32'(fifo_ren),         0);
        check("bp_valid", 32'(s_if.m_valid_o),   1);
        check("bp_data",  32'(s_if.m_data_o),    32'h20);
        check("bp_last",  32'(s_if.m_last_o),    0);
        s_if.m_ready_i = 1'b1;
        cycles(25);
        check_beats("bp", base, 8, 8'h20, 8'b1000_1000);

        // Timeout: three words, burst enters 16 cycles after first occupancy
        base = recv.size();
        wr(3, 8'h30);
        cycles(13);
        check("to_ren_early",  32'(fifo_ren), 0);
        check("to_busy_early", 32'(busy),     0);
        @(negedge clk);
        check("to_ren_fire",  32'(fifo_ren), 1);
        check("to_busy_fire", 32'(busy),     1);
        cycles(8);
        check_beats("to", base, 3, 8'h30, 8'b0000_0100);

        // Flush pulse in IDLE
        base = recv.size();
        wr(2, 8'h40);
        check("fl_ren_pre", 32'(fifo_ren), 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_ren", 32'(fifo_ren), 1);
        cycles(8);
        check_beats("fl", base, 2, 8'h40, 8'b0000_0010);

        // Flush held during a burst does not truncate it
        base = recv.size();
        wr(6, 8'h50);
        flush = 1'b1;
        cycles(12);
        flush = 1'b0;
        check_beats("flb", base, 6, 8'h50, 8'b0010_1000);

        // FWFT stall mid-burst
        base  = recv.size();
        pops0 = pop_cnt;
        wr(4, 8'h60);
        @(negedge clk);
        check("st_ren_pre", 32'(fifo_ren), 1);
        @(negedge clk);
        stall = 1'b1;
        #1;
        check("st_ren0", 32'(fifo_ren), 0);
        @(negedge clk);
        check("st_ren1", 32'(fifo_ren), 0);
        @(negedge clk);
        check("st_ren2", 32'(fifo_ren), 0);
        check("st_busy", 32'(busy),     1);
        @(negedge clk);
        stall = 1'b0;
        cycles(10);
        check("st_pops", 32'(pop_cnt - pops0), 4);
        check_beats("st", base, 4, 8'h60, 8'b0000_1000);

        // Async reset after two pops
        pops0 = pop_cnt;
        s_if.m_ready_i = 1'b0;
        wr(4, 8'h70);
        cycles(3);
        check("ar_pops", 32'(pop_cnt - pops0), 2);
        rst = 1'b1;
        #1;
        check("ar_ren",   32'(fifo_ren),       0);
        check("ar_valid", 32'(s_if.m_valid_o), 0);
        check("ar_data",  32'(s_if.m_data_o),  0);
        check("ar_last",  32'(s_if.m_last_o),  0);
        check("ar_busy",  32'(busy),           0);
        @(negedge clk);
        rst = 1'b0;
        s_if.m_ready_i = 1'b1;
        base = recv.size();
        @(negedge clk);
        check("ar_valid_post", 32'(s_if.m_valid_o), 0);
        check("ar_busy_post",  32'(busy),           0);
        wr(2, 8'h74);
        cycles(12);
        check_beats("ar", base, 4, 8'h72, 8'b0000_1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
